// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
// The optional early divide-by-zero path is enabled by MULTDIV_DIV0_EARLY_EN.
package multdiv_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    localparam logic [DEFAULT_WIDTH-1:0] INT_MIN = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX,
        DONE
    } state_t;

    typedef enum logic {
        OP_MUL,
        OP_DIV
    } op_t;

endpackage

// File: rtl/multdiv_step.sv
// One iteration of the shared datapath: shift-add for multiply and
// shift/trial-subtract (restoring) for divide, on unsigned magnitudes.
module multdiv_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH:0]   trial;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        next_hi = acc_hi;
        next_lo = acc_lo;

        sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        // The remainder stays below the divisor, so its top bit is always clear.
        rem_sh = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
        trial  = {1'b0, rem_sh} - {1'b0, opnd};

        if (op == OP_MUL) begin
            {next_hi, next_lo} = {sum, acc_lo[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            next_hi = trial[WIDTH-1:0];
            next_lo = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            next_hi = rem_sh;
            next_lo = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/multdiv.sv
// Iterative signed multiply/divide: FSM, iteration counter, sign fix-up and
// output registers. Define MULTDIV_DIV0_EARLY_EN for the early divide-by-zero path.
module multdiv
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             status_busy
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, next_state;
    op_t              op;
    logic [CW-1:0]    count;
    logic             neg;
    logic             div0;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             start, early_div0, last_iter;

    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH:0]     prod_top;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   fix_result;
    logic               fix_exception;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign mag_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign mag_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign last_iter = (count == CW'(WIDTH - 1));

`ifdef MULTDIV_DIV0_EARLY_EN
    assign early_div0 = ctrl_DIV && !ctrl_MULT && (data_operandB == '0);
`else
    assign early_div0 = 1'b0;
`endif

    assign status_busy = (state == ITER) || (state == FIX);

    multdiv_step #(.WIDTH(WIDTH)) u_step (
        .op      (op),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .opnd    (opnd),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses <= so all registers update from pre-edge values.
        if (ctrl_reset) state <= IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = IDLE;
            ITER:    if (last_iter) next_state = FIX;
            FIX:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // A start in any state aborts whatever is in flight.
        if (start) next_state = early_div0 ? DONE : ITER;
    end

    always_comb begin
        prod_s   = neg ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        prod_top = prod_s[2*WIDTH-1:WIDTH-1];
        quo_s    = neg ? -acc_lo : acc_lo;

        fix_result    = '0;
        fix_exception = 1'b0;
        if (op == OP_MUL) begin
            fix_result    = prod_s[WIDTH-1:0];
            fix_exception = !((&prod_top) || (prod_top == '0));
        end else if (div0) begin
            fix_result    = '0;
            fix_exception = 1'b1;
        end else begin
            // Only INT_MIN / -1 yields a positive quotient with the top bit set.
            fix_result    = quo_s;
            fix_exception = acc_lo[WIDTH-1] && !neg;
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            op             <= OP_MUL;
            neg            <= 1'b0;
            div0           <= 1'b0;
            count          <= '0;
            acc_hi         <= '0;
            acc_lo         <= '0;
            opnd           <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= (state == DONE) && !start;
            if (start) begin
                op     <= ctrl_MULT ? OP_MUL : OP_DIV;
                neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div0   <= (data_operandB == '0);
                count  <= '0;
                acc_hi <= '0;
                acc_lo <= ctrl_MULT ? mag_b : mag_a;
                opnd   <= ctrl_MULT ? mag_a : mag_b;
                if (early_div0) begin
                    data_result    <= '0;
                    data_exception <= 1'b1;
                end
            end else if (state == ITER) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                count  <= count + CW'(1);
            end else if (state == FIX) begin
                data_result    <= fix_result;
                data_exception <= fix_exception;
            end
        end
    end

endmodule
